trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DEPTH, 16, number of entries; power of two, >= 2.
REQ-002 Parameter DW, 32, width of trace address and trace data fields.
REQ-003 Port clk  in  1  sole clock; all state updates on posedge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port trace_val  in  1  processor commit strobe.
REQ-006 Port trace_addr  in  DW  committed write-back register/address.
REQ-007 Port trace_data  in  DW  committed write-back data.
REQ-008 Port mode  in  1  full policy: 0 = drop newest, 1 = overwrite oldest.
REQ-009 Port clear  in  1  synchronous flush request.
REQ-010 Port deq_val  out  1  head entry valid.
REQ-011 Port deq_rdy  in  1  consumer accepts head.
REQ-012 Port deq_addr  out  DW  head entry address.
REQ-013 Port deq_data  out  DW  head entry data.
REQ-014 Port deq_cycle  out  32  head entry timestamp (see Configuration).
REQ-015 Port count  out  $clog2(DEPTH)+1  occupied entries.
REQ-016 Port overflow  out  1  sticky: at least one entry lost since reset/clear.
REQ-017 Port drop_cnt  out  16  entries lost; saturates at 0xFFFF.

Function
REQ-018 Enqueue SHALL occur on posedge when trace_val=1; entry visible at deq_* next cycle (1-cycle latency, no same-cycle bypass).
REQ-019 deq_val SHALL equal (count != 0); deq_addr/deq_data/deq_cycle SHALL combinationally present the head entry (first-word-fall-through).
REQ-020 Dequeue SHALL occur on posedge when deq_val=1 and deq_rdy=1; deq_rdy while empty SHALL have no effect.
REQ-021 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when full; no loss counted.
REQ-023 Full, enqueue, no dequeue, mode=0: new entry discarded; contents unchanged; drop_cnt increments; overflow set.
REQ-024 Full, enqueue, no dequeue, mode=1: oldest entry discarded, head advances, new entry written at tail; count stays DEPTH; drop_cnt increments; overflow set.
REQ-025 mode SHALL be sampled every cycle; changing it never alters stored entries.
REQ-026 clear=1 SHALL, next cycle, empty the buffer (count=0), clear overflow and drop_cnt; a same-cycle enqueue or dequeue is ignored and not counted as a drop.
REQ-027 drop_cnt SHALL hold at 0xFFFF once reached; overflow remains 1 until rst or clear.

Reset
REQ-028 rst=1 at posedge SHALL set count=0, pointers=0, overflow=0, drop_cnt=0, timestamp counter=0; deq_val=0 the following cycle.
REQ-029 rst SHALL take priority over clear, enqueue and dequeue in the same cycle; entry storage contents need not be reset.
REQ-030 rst asserted mid-operation SHALL discard all entries; no partial state survives.

Configuration
REQ-031 Macro TRACE_BUFFER_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (wraps at 2^32, reset to 0) is stored with each enqueued entry and driven on deq_cycle.
REQ-032 Macro TRACE_BUFFER_TIMESTAMP_EN undefined: no counter or timestamp storage is built; deq_cycle SHALL be constant 0; all other behaviour identical.

Verification
REQ-033 DEPTH=4, enqueue (0x1,0xA),(0x2,0xB), deq_rdy=1 -> deq returns (0x1,0xA) then (0x2,0xB), count 1->2->1->0, deq_val=0 after.
REQ-034 DEPTH=4, mode=0, enqueue 6 entries with deq_rdy=0 -> count=4, head=entry1, drop_cnt=2, overflow=1.
REQ-035 DEPTH=4, mode=1, enqueue 6 entries with deq_rdy=0 -> count=4, deq order entries 3,4,5,6, drop_cnt=2.
REQ-036 Full buffer, trace_val=1 and deq_rdy=1 same cycle -> count stays 4, drop_cnt unchanged, pointers wrap correctly over 3 wraps.
REQ-037 clear=1 with trace_val=1 on full buffer -> next cycle count=0, overflow=0, drop_cnt=0; rst with clear and trace_val -> same state.
REQ-038 TRACE_BUFFER_TIMESTAMP_EN defined, enqueue at cycles 5 and 9 after reset -> deq_cycle 5 then 9; undefined -> deq_cycle 0.

Source files
------------

// File: rtl/trace_buffer_if.sv
// Trace buffer bus: producer commit stream, consumer dequeue port and status.
interface trace_buffer_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          trace_val;
    logic [DW-1:0] trace_addr;
    logic [DW-1:0] trace_data;
    logic          mode;
    logic          clear;
    logic          deq_val;
    logic          deq_rdy;
    logic [DW-1:0] deq_addr;
    logic [DW-1:0] deq_data;
    logic [31:0]   deq_cycle;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   drop_cnt;

    modport master (
        output trace_val, trace_addr, trace_data, mode, clear, deq_rdy,
        input  deq_val, deq_addr, deq_data, deq_cycle, count, overflow, drop_cnt
    );

    modport slave (
        input  trace_val, trace_addr, trace_data, mode, clear, deq_rdy,
        output deq_val, deq_addr, deq_data, deq_cycle, count, overflow, drop_cnt
    );
endinterface

// File: rtl/trace_buffer.sv
// Commit trace FIFO with drop-newest / overwrite-oldest full policy,
// first-word-fall-through head and sticky loss accounting.
// Optional feature macro: TRACE_BUFFER_TIMESTAMP_EN stores a free-running
// 32-bit cycle stamp with each entry; without it deq_cycle is tied to 0.
module trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    trace_buffer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] head_q,  head_d;
    logic [AW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q,  drop_d;
    logic          wr_en;
    logic          lost;
    logic          do_deq;
    logic          full;

    logic [DW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    // Next-state: clear wins, then enqueue/dequeue/full-policy resolution
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        wr_en      = 1'b0;
        lost       = 1'b0;
        do_deq     = (count_q != CW'(0)) && bus.deq_rdy;
        full       = (count_q == CW'(DEPTH));

        if (bus.clear) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (bus.trace_val) begin
                if (!full || do_deq) begin
                    // Room available (or freed by this cycle's dequeue)
                    wr_en  = 1'b1;
                    tail_d = tail_q + AW'(1);
                    if (do_deq) begin
                        head_d = head_q + AW'(1);
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    lost = 1'b1;
                    if (bus.mode) begin
                        // Full means tail == head: the write replaces the oldest entry
                        wr_en  = 1'b1;
                        tail_d = tail_q + AW'(1);
                        head_d = head_q + AW'(1);
                    end
                end
            end else if (do_deq) begin
                head_d  = head_q + AW'(1);
                count_d = count_q - CW'(1);
            end

            if (lost) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            addr_mem[tail_q] <= bus.trace_addr;
            data_mem[tail_q] <= bus.trace_data;
        end
    end

`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_mem [DEPTH];

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    // Timestamp storage alongside each entry
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            ts_mem[tail_q] <= ts_q;
        end
    end

    assign bus.deq_cycle = ts_mem[head_q];
`else
    assign bus.deq_cycle = 32'd0;
`endif

    assign bus.deq_val  = (count_q != CW'(0));
    assign bus.deq_addr = addr_mem[head_q];
    assign bus.deq_data = data_mem[head_q];
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Randomized + directed bench for trace_buffer against a queue-based model.
module tb_trace_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    trace_buffer_if #(.DEPTH(DEPTH), .DW(DW)) bif ();

    trace_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] t;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    int          m_drop;
    logic [31:0] m_ts;

    // Model advance for one clock edge, using the inputs held across that edge
    task automatic model_update();
        ent_t e;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            m_ts   = 32'd0;
        end else begin
            e.a = bif.trace_addr;
            e.d = bif.trace_data;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
            e.t = m_ts;
`else
            e.t = 32'd0;
`endif
            m_ts = m_ts + 32'd1;
            if (bif.clear) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_drop = 0;
            end else begin
                if (mq.size() > 0 && bif.deq_rdy) void'(mq.pop_front());
                if (bif.trace_val) begin
                    if (mq.size() < int'(DEPTH)) begin
                        mq.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < 65535) m_drop++;
                        if (bif.mode) begin
                            void'(mq.pop_front());
                            mq.push_back(e);
                        end
                    end
                end
            end
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Apply inputs at a falling edge, take one rising edge, return at next falling edge
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic r, input logic m, input logic c, input logic rs);
        bif.trace_val  = v;
        bif.trace_addr = a;
        bif.trace_data = d;
        bif.deq_rdy    = r;
        bif.mode       = m;
        bif.clear      = c;
        rst            = rs;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic enq(input int i, input logic m);
        step(1'b1, 32'(i), 32'h100 + 32'(i), 1'b0, m, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Per-cycle comparison of every DUT output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                lit("deq_val",  32'(bif.deq_val),  32'(mq.size() != 0));
                lit("count",    32'(bif.count),    32'(mq.size()));
                lit("overflow", 32'(bif.overflow), 32'(m_ovf));
                lit("drop_cnt", 32'(bif.drop_cnt), 32'(m_drop));
                if (mq.size() != 0) begin
                    lit("deq_addr",  bif.deq_addr,  mq[0].a);
                    lit("deq_data",  bif.deq_data,  mq[0].d);
                    lit("deq_cycle", bif.deq_cycle, mq[0].t);
                end
            end
        end
    end

    // Stimulus: directed scenarios with literal expectations, then random traffic
    initial begin
        logic [31:0] ts_a;
        logic [31:0] ts_b;
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        m_ts     = 32'd0;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        ts_a = 32'd5;
        ts_b = 32'd9;
`else
        ts_a = 32'd0;
        ts_b = 32'd0;
`endif
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        lit("rst_count",   32'(bif.count),    32'd0);
        lit("rst_deq_val", 32'(bif.deq_val),  32'd0);
        lit("rst_ovf",     32'(bif.overflow), 32'd0);

        // Two entries in, then drain
        step(1'b1, 32'h1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("b1_count1", 32'(bif.count), 32'd1);
        step(1'b1, 32'h2, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0);
        lit("b1_count2", 32'(bif.count), 32'd2);
        lit("b1_head1a", bif.deq_addr, 32'h1);
        lit("b1_head1d", bif.deq_data, 32'hA);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit("b1_count3", 32'(bif.count), 32'd1);
        lit("b1_head2a", bif.deq_addr, 32'h2);
        lit("b1_head2d", bif.deq_data, 32'hB);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit("b1_count4", 32'(bif.count), 32'd0);
        lit("b1_val_end", 32'(bif.deq_val), 32'd0);

        // Drop-newest on full
        for (int i = 1; i <= 6; i++) enq(i, 1'b0);
        lit("dn_count", 32'(bif.count), 32'd4);
        lit("dn_head",  bif.deq_addr, 32'd1);
        lit("dn_drop",  32'(bif.drop_cnt), 32'd2);
        lit("dn_ovf",   32'(bif.overflow), 32'd1);
        lit("dn_model", 32'(mq.size()), 32'd4);

        // Clear with a same-cycle enqueue on a full buffer
        step(1'b1, 32'h77, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        lit("clr_count", 32'(bif.count), 32'd0);
        lit("clr_ovf",   32'(bif.overflow), 32'd0);
        lit("clr_drop",  32'(bif.drop_cnt), 32'd0);

        // Overwrite-oldest on full
        for (int i = 1; i <= 6; i++) enq(i, 1'b1);
        lit("ow_count", 32'(bif.count), 32'd4);
        lit("ow_drop",  32'(bif.drop_cnt), 32'd2);
        for (int k = 3; k <= 6; k++) begin
            lit("ow_order", bif.deq_addr, 32'(k));
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        lit("ow_empty", 32'(bif.deq_val), 32'd0);

        // Full buffer with simultaneous enqueue/dequeue across three pointer wraps
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) enq(i, 1'b0);
        for (int i = 5; i <= 16; i++)
            step(1'b1, 32'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        lit("wr_count", 32'(bif.count), 32'd4);
        lit("wr_drop",  32'(bif.drop_cnt), 32'd0);
        lit("wr_head",  bif.deq_addr, 32'd13);
        lit("wr_data",  bif.deq_data, 32'h10D);

        // Reset wins over clear and enqueue
        enq(20, 1'b0);
        enq(21, 1'b0);
        step(1'b1, 32'h99, 32'h99, 1'b1, 1'b1, 1'b1, 1'b1);
        lit("rc_count", 32'(bif.count), 32'd0);
        lit("rc_ovf",   32'(bif.overflow), 32'd0);
        lit("rc_drop",  32'(bif.drop_cnt), 32'd0);
        lit("rc_val",   32'(bif.deq_val), 32'd0);

        // Timestamps: enqueue at cycles 5 and 9 after reset
        for (int i = 0; i < 5; i++) idle();
        enq(50, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        enq(90, 1'b0);
        lit("ts_first", bif.deq_cycle, ts_a);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit("ts_second", bif.deq_cycle, ts_b);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 60,
                 $urandom(), $urandom(),
                 $urandom_range(99) < 45,
                 1'($urandom_range(1)),
                 $urandom_range(99) < 2,
                 $urandom_range(199) == 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
